// File: rtl/oai22_arc_tester.sv
// oai22_arc_tester
//   Characterization sequencer for one OAI22 cell (ZN = ~((A1|A2)&(B1|B2))).
//   On start_i it walks the 12 single-input sensitized arcs. Each arc has three
//   phases: INIT, RISE and FALL. For every phase it drives the cell, waits SETTLE
//   cycles and then compares zn_i with the value the OAI22 function gives for the
//   registered drives. It counts mismatches and records the index of the first
//   failing check.
// Ports
//   ck_i          clock, rising edge
//   rst_i         synchronous active-high reset
//   start_i       begins a run (sampled in idle only)
//   zn_i          output of the cell under test
//   a1_o..b2_o    registered drives to the cell under test
//   busy_o        run in progress (drive/settle/check)
//   done_o        one-cycle pulse at run completion
//   pass_o        last completed run had no mismatches
//   err_cnt_o     saturating mismatch count
//   first_err_o   arc*3+phase of the first failing check, 63 if none
//   arc_idx_o     current arc, 0..11
module oai22_arc_tester #(
   parameter int unsigned SETTLE = 2,
   parameter int unsigned CNT_W  = 8
) (
   input  logic             ck_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             zn_i,
   output logic             a1_o,
   output logic             a2_o,
   output logic             b1_o,
   output logic             b2_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             pass_o,
   output logic [CNT_W-1:0] err_cnt_o,
   output logic [5:0]       first_err_o,
   output logic [3:0]       arc_idx_o
);

   typedef enum logic [2:0] {StIdle, StDrive, StSettle, StCheck, StFinish} state_e;

   localparam logic [5:0] NoErr      = 6'd63;
   localparam logic [7:0] SettleLast = 8'(SETTLE - 1);

   state_e           state_q, state_d;
   logic [3:0]       arc_q, arc_d;
   logic [1:0]       phase_q, phase_d;
   logic [7:0]       wait_q, wait_d;
   logic [3:0]       drv_q, drv_d;     // {A1, A2, B1, B2}
   logic [CNT_W-1:0] err_q, err_d;
   logic [5:0]       ferr_q, ferr_d;
   logic             pass_q, pass_d;

   // Drive vector for the current arc/phase.
   logic [1:0] grp;       // which pin switches: 0=A1 1=A2 2=B1 3=B2
   logic [1:0] sub;       // arc position inside its group
   logic [1:0] sub_p1;
   logic [2:0] side;      // side-input values, in pin order with the switching pin removed
   logic       sw;
   logic [3:0] arc_vec;

   always_comb begin
      grp = 2'd3;
      sub = 2'(arc_q - 4'd9);
      if (arc_q < 4'd3) begin
         grp = 2'd0;
         sub = 2'(arc_q);
      end else if (arc_q < 4'd6) begin
         grp = 2'd1;
         sub = 2'(arc_q - 4'd3);
      end else if (arc_q < 4'd9) begin
         grp = 2'd2;
         sub = 2'(arc_q - 4'd6);
      end
      sub_p1 = sub + 2'd1;
      // A-arcs need a B side input high (001/010/011); B-arcs need an A side high
      // (010/100/110), so the pattern is shifted up by one pin.
      side = grp[1] ? {sub_p1, 1'b0} : {1'b0, sub_p1};
      sw   = (phase_q == 2'd1);
      unique case (grp)
         2'd0:    arc_vec = {sw, side};
         2'd1:    arc_vec = {side[2], sw, side[1:0]};
         2'd2:    arc_vec = {side[2:1], sw, side[0]};
         default: arc_vec = {side, sw};
      endcase
   end

   logic       expected;
   logic       mismatch;
   logic [5:0] check_idx;

   assign expected  = ~((drv_q[3] | drv_q[2]) & (drv_q[1] | drv_q[0]));
   assign mismatch  = (zn_i != expected);
   assign check_idx = ({2'b00, arc_q} << 1) + {2'b00, arc_q} + {4'b0000, phase_q};

   always_comb begin
      state_d = state_q;
      arc_d   = arc_q;
      phase_d = phase_q;
      wait_d  = wait_q;
      drv_d   = drv_q;
      err_d   = err_q;
      ferr_d  = ferr_q;
      pass_d  = pass_q;
      unique case (state_q)
         StIdle: begin
            drv_d = '0;
            if (start_i) begin
               state_d = StDrive;
               arc_d   = 4'd0;
               phase_d = 2'd0;
               err_d   = '0;
               ferr_d  = NoErr;
               pass_d  = 1'b0;
            end
         end
         StDrive: begin
            drv_d   = arc_vec;
            wait_d  = SettleLast;
            state_d = StSettle;
         end
         StSettle: begin
            if (wait_q == 8'd0) begin
               state_d = StCheck;
            end else begin
               wait_d = wait_q - 8'd1;
            end
         end
         StCheck: begin
            if (mismatch) begin
               if (err_q != '1) begin
                  err_d = err_q + 1'b1;
               end
               if (ferr_q == NoErr) begin
                  ferr_d = check_idx;
               end
            end
            if (phase_q != 2'd2) begin
               phase_d = phase_q + 2'd1;
               state_d = StDrive;
            end else if (arc_q != 4'd11) begin
               arc_d   = arc_q + 4'd1;
               phase_d = 2'd0;
               state_d = StDrive;
            end else begin
               state_d = StFinish;
               pass_d  = (err_d == '0);
            end
         end
         StFinish: begin
            drv_d   = '0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge ck_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         arc_q   <= 4'd0;
         phase_q <= 2'd0;
         wait_q  <= 8'd0;
         drv_q   <= '0;
         err_q   <= '0;
         ferr_q  <= NoErr;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         arc_q   <= arc_d;
         phase_q <= phase_d;
         wait_q  <= wait_d;
         drv_q   <= drv_d;
         err_q   <= err_d;
         ferr_q  <= ferr_d;
         pass_q  <= pass_d;
      end
   end

   assign {a1_o, a2_o, b1_o, b2_o} = drv_q;
   assign busy_o      = (state_q == StDrive) || (state_q == StSettle) || (state_q == StCheck);
   assign done_o      = (state_q == StFinish);
   assign pass_o      = pass_q;
   assign err_cnt_o   = err_q;
   assign first_err_o = ferr_q;
   assign arc_idx_o   = arc_q;

endmodule
